// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and requester port ids shared by mem_arbiter and its bench
package mem_arb_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and ram buses around mem_arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 32);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_err;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] m_r_addr;
    logic [ADDR_W-1:0] m_w_addr;
    logic [31:0]       m_w_line;
    logic              m_read;
    logic              m_write;
    logic [31:0]       m_r_line;
    logic              m_rrdy;
    logic              m_wrdy;
    logic              m_exc;
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_r_line, m_rrdy, m_wrdy, m_exc,
        output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata, m_r_addr, m_w_addr, m_w_line, m_read, m_write
    );
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_r_line, m_rrdy, m_wrdy, m_exc,
        input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata, m_r_addr, m_w_addr, m_w_line, m_read, m_write
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin picker; on a tie the port not granted last wins
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_id
);
    assign grant_valid = |req;
    assign grant_id = &req ? ~last : req[PORT_D];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and load/store accesses onto a single-ported ram,
// one registered strobe per access and one-cycle ack/err pulses back to the winner
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
    logic [1:0]        state;
    logic              last;
    logic              port;
    logic              we;
    logic              grant_valid;
    logic              grant_id;
    logic              wr;
    logic              ok;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr;
    rr_arb2 u_arb (
        .req         ({bus.d_req, bus.i_req}),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );
    assign wr = grant_id == PORT_D && bus.d_we;
    assign addr = grant_id == PORT_D ? bus.d_addr : bus.i_addr;
    // ready outranks exc: the ram leaves exc set until its next successful access
    assign ok = we ? bus.m_wrdy : bus.m_rrdy;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last         <= PORT_I;
            port         <= PORT_I;
            we           <= 1'b0;
            cnt          <= '0;
            bus.i_ack    <= 1'b0;
            bus.i_err    <= 1'b0;
            bus.i_rdata  <= '0;
            bus.d_ack    <= 1'b0;
            bus.d_err    <= 1'b0;
            bus.d_rdata  <= '0;
            bus.m_r_addr <= '0;
            bus.m_w_addr <= '0;
            bus.m_w_line <= '0;
            bus.m_read   <= 1'b0;
            bus.m_write  <= 1'b0;
        end else begin
            bus.i_ack   <= 1'b0;
            bus.i_err   <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.d_err   <= 1'b0;
            bus.m_read  <= 1'b0;
            bus.m_write <= 1'b0;
            case (state)
                IDLE: if (grant_valid) begin
                    state        <= ISSUE;
                    last         <= grant_id;
                    port         <= grant_id;
                    we           <= wr;
                    bus.m_read   <= !wr;
                    bus.m_write  <= wr;
                    bus.m_r_addr <= addr;
                    bus.m_w_addr <= addr;
                    if (grant_id == PORT_D) bus.m_w_line <= bus.d_wdata;
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: if (ok || bus.m_exc || cnt == TMAX) begin
                    state <= RESP;
                    if (port == PORT_D) begin
                        bus.d_ack <= 1'b1;
                        bus.d_err <= !ok;
                        if (ok && !we) bus.d_rdata <= bus.m_r_line;
                    end else begin
                        bus.i_ack <= 1'b1;
                        bus.i_err <= !ok;
                        if (ok) bus.i_rdata <= bus.m_r_line;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized rounds against a transaction-level model; a monitor
// pops the scoreboard on every ack and checks port, cycle, err and rdata
module tb_mem_arbiter;
    import mem_arb_pkg::*;
    localparam int AW  = 32;
    localparam int TO  = 4;
    localparam int MEM = 1024;
    typedef struct {
        logic        port;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int fails = 0;
    int strobes = 0;
    exp_t q[$];
    logic [31:0] ref_mem [MEM];
    logic [31:0] ram_mem [MEM];
    logic last_m;
    logic exc_m;
    logic op_we, f_we, fire;
    logic [AW-1:0] op_addr, f_addr;
    logic [31:0] op_data, f_data;
    int dly = 0;
    int ram_lat = 0;
    bit ram_dead = 1'b0;

    mem_arbiter_if #(.ADDR_W(AW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int a);
        return a == 5 ? 32'hDEADBEEF : 32'h1000_0000 + 32'(a) * 32'h0101_0101;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return $urandom_range(0, 7) == 0 ? AW'(MEM + $urandom_range(0, 5000)) : AW'($urandom_range(0, 15));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ram environment: answers after ram_lat extra cycles, exc sticky until next success
    always_comb begin
        f_we = op_we;
        f_addr = op_addr;
        f_data = op_data;
        fire = dly == 1;
        if (bus.m_read || bus.m_write) begin
            f_we = bus.m_write;
            f_addr = bus.m_write ? bus.m_w_addr : bus.m_r_addr;
            f_data = bus.m_w_line;
            fire = !ram_dead && (ram_lat == 0 || bus.m_exc);
        end
    end

    always @(posedge clk) begin
        bus.m_rrdy <= 1'b0;
        bus.m_wrdy <= 1'b0;
        bus.m_r_line <= 32'hBAD0_BAD0;
        if (rst) begin
            dly <= 0;
            bus.m_exc <= 1'b0;
            for (int i = 0; i < MEM; i++) ram_mem[i] <= init_word(i);
        end else begin
            if (bus.m_read || bus.m_write) begin
                op_we <= f_we;
                op_addr <= f_addr;
                op_data <= f_data;
                dly <= (ram_dead || fire) ? 0 : ram_lat;
            end else if (dly > 0) begin
                dly <= dly - 1;
            end
            if (fire) begin
                if (f_addr < MEM) begin
                    bus.m_exc <= 1'b0;
                    if (f_we) begin
                        ram_mem[f_addr[9:0]] <= f_data;
                        bus.m_wrdy <= 1'b1;
                    end else begin
                        bus.m_rrdy <= 1'b1;
                        bus.m_r_line <= ram_mem[f_addr[9:0]];
                    end
                end else begin
                    bus.m_exc <= 1'b1;
                end
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            strobes = 0;
        end else begin
            if (bus.m_read || bus.m_write) strobes++;
            if (bus.i_ack || bus.d_ack) begin
                check("ack_expected", 32'(q.size() != 0), 32'd1);
                check("ack_onehot", {31'b0, bus.i_ack & bus.d_ack}, 32'd0);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("ack_port", {31'b0, bus.d_ack}, {31'b0, e.port});
                    check("ack_cycle", cyc, e.cyc);
                    check("ack_err", {31'b0, e.port ? bus.d_err : bus.i_err}, {31'b0, e.err});
                    if (e.chk) check("rdata", e.port ? bus.d_rdata : bus.i_rdata, e.rdata);
                    check("strobes_per_access", strobes, 32'd1);
                end
                strobes = 0;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < MEM; i++) ref_mem[i] = init_word(i);
        last_m = PORT_I;
        exc_m = 1'b0;
        q.delete();
    endtask

    // one access served starting in IDLE cycle t; t advances to the next IDLE cycle
    task automatic expect_access(input logic p, input logic [AW-1:0] a, input logic w,
                                 input logic [31:0] wd, input int lat, inout int t);
        exp_t e;
        int dur;
        e.port = p;
        e.chk = 1'b0;
        e.rdata = '0;
        if (ram_dead) begin
            e.err = 1'b1;
            dur = exc_m ? 3 : 2 + TO;
        end else if (a < MEM) begin
            e.err = 1'b0;
            dur = 3 + (exc_m ? 0 : lat);
            exc_m = 1'b0;
            if (w) ref_mem[a[9:0]] = wd;
            else begin
                e.chk = 1'b1;
                e.rdata = ref_mem[a[9:0]];
            end
        end else begin
            e.err = 1'b1;
            dur = 3 + (exc_m ? 0 : lat);
            exc_m = 1'b1;
        end
        e.cyc = t + dur;
        q.push_back(e);
        t = e.cyc + 1;
        last_m = p;
    endtask

    task automatic wait_ack(input logic p);
        logic got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = p ? bus.d_ack : bus.i_ack;
        end
        check(p ? "d_ack_seen" : "i_ack_seen", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (p) bus.d_req = 1'b0;
        else bus.i_req = 1'b0;
    endtask

    // called #1 after a rising edge with the arbiter in IDLE; returns likewise
    task automatic round(input logic ri, input logic rd, input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic dw, input logic [31:0] wd, input int lat);
        int t = cyc;
        ram_lat = lat;
        bus.i_req = ri;
        bus.i_addr = ia;
        bus.d_req = rd;
        bus.d_addr = da;
        bus.d_we = dw;
        bus.d_wdata = wd;
        if (ri && rd && last_m == PORT_I) begin
            expect_access(PORT_D, da, dw, wd, lat, t);
            expect_access(PORT_I, ia, 1'b0, wd, lat, t);
        end else if (ri && rd) begin
            expect_access(PORT_I, ia, 1'b0, wd, lat, t);
            expect_access(PORT_D, da, dw, wd, lat, t);
        end else if (rd) begin
            expect_access(PORT_D, da, dw, wd, lat, t);
        end else if (ri) begin
            expect_access(PORT_I, ia, 1'b0, wd, lat, t);
        end
        fork
            begin if (ri) wait_ack(PORT_I); end
            begin if (rd) wait_ack(PORT_D); end
        join
    endtask

    initial begin
        logic ri, rd;
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_ack", {31'b0, bus.i_ack}, 32'd0);
        check("rst_d_ack", {31'b0, bus.d_ack}, 32'd0);
        check("rst_i_err", {31'b0, bus.i_err}, 32'd0);
        check("rst_d_err", {31'b0, bus.d_err}, 32'd0);
        check("rst_m_read", {31'b0, bus.m_read}, 32'd0);
        check("rst_m_write", {31'b0, bus.m_write}, 32'd0);
        check("rst_i_rdata", bus.i_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_m_r_addr", bus.m_r_addr, 32'd0);
        check("rst_m_w_addr", bus.m_w_addr, 32'd0);
        check("rst_m_w_line", bus.m_w_line, 32'd0);
        rst = 1'b0;
        repeat (2) round(1'b1, 1'b1, 32'd1, 32'd2, 1'b0, 32'h0, 0);
        round(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 32'h0, 0);
        round(1'b0, 1'b1, 32'd0, 32'd10, 1'b1, 32'h12345678, 0);
        round(1'b0, 1'b1, 32'd0, 32'd10, 1'b0, 32'h0, 0);
        round(1'b0, 1'b1, 32'd0, 32'd2000, 1'b0, 32'h0, 0);
        round(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'h0, 0);
        ram_dead = 1'b1;
        round(1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 32'h0, 0);
        ram_dead = 1'b0;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'd7;
        bus.d_wdata = 32'hCAFEF00D;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_i_ack", {31'b0, bus.i_ack}, 32'd0);
        check("rst_mid_d_ack", {31'b0, bus.d_ack}, 32'd0);
        check("rst_mid_m_read", {31'b0, bus.m_read}, 32'd0);
        check("rst_mid_m_write", {31'b0, bus.m_write}, 32'd0);
        rst = 1'b0;
        model_reset();
        round(1'b1, 1'b1, 32'd3, 32'd4, 1'b0, 32'h0, 0);
        for (int n = 0; n < 150; n++) begin
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!ri && !rd) rd = 1'b1;
            round(ri, rd, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 2));
        end
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d failures", checks, fails);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported `ram` block between the instruction-fetch unit (read-only) and the load/store unit (read/write). It serialises requests with a round-robin policy and drives the ram's `read`/`write` strobes for exactly one cycle per access. It captures `r_line` on the response cycle, because the ram tri-states `r_line` when idle. Completion, fault and timeout are returned to the granted requester as one-cycle pulses.

## Interface
Parameters:
- `ADDR_W`, 32: address width of requester and ram ports.
- `TIMEOUT`, 4: cycles spent in WAIT without `rrdy`/`wrdy`/`exc` before a timeout fault is reported; minimum 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request; held high until `i_ack`.
- `i_addr` in ADDR_W: fetch word address.
- `i_ack` out 1: one-cycle completion pulse for fetch.
- `i_err` out 1: valid with `i_ack`; 1 = ram exception or timeout.
- `i_rdata` out 32: fetched word; valid with `i_ack`, held until the next fetch ack.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data word address.
- `d_wdata` in 32: write data.
- `d_ack` out 1: one-cycle completion pulse for data.
- `d_err` out 1: valid with `d_ack`.
- `d_rdata` out 32: read word; valid with `d_ack`, held until the next data ack.
- `m_r_addr`, `m_w_addr` out ADDR_W: to ram.
- `m_w_line` out 32: to ram.
- `m_read`, `m_write` out 1: ram strobes.
- `m_r_line` in 32: from ram.
- `m_rrdy`, `m_wrdy`, `m_exc` in 1: from ram.

## Operation
- FSM states:
  - IDLE: arbitrate. If any request is pending, latch the winner's port id, addr, we and wdata, then go to ISSUE.
  - ISSUE: assert `m_read` (or `m_write`) with the latched addr/data for exactly one cycle, then go to WAIT with the timeout counter at 0.
  - WAIT: decide the outcome of the access.
    - `m_rrdy` (read) or `m_wrdy` (write) high: success. Capture `m_r_line` for reads, then go to RESP with err=0.
    - Otherwise `m_exc` high: go to RESP with err=1.
    - Otherwise: increment the counter. When the counter reaches TIMEOUT-1, go to RESP with err=1.
  - RESP: pulse the ack of the latched port, drive its err and rdata, then go to IDLE.
- Ready has priority over `m_exc` in WAIT, because the ram's `exc` is sticky until its next successful access.
- Arbitration: two-way round-robin. The `last` pointer records the last granted port; if both request, the other port wins. After reset `last` = fetch, so data wins the first tie. The pointer updates only on the IDLE→ISSUE transition.
- A fetch is always issued as a read; fetch requests ignore `d_we`.
- Requester inputs are sampled only in IDLE. Changes while a request is in flight are ignored until the ack.
- Ram address/data outputs hold the latched values outside ISSUE; strobes are 0 outside ISSUE.

## Timing
- Reset values:
  - state = IDLE, `last` = fetch.
  - `i_ack`, `d_ack`, `i_err`, `d_err`, `m_read`, `m_write` = 0.
  - `i_rdata`, `d_rdata`, `m_r_addr`, `m_w_addr`, `m_w_line` = 0.
- Nominal latency: request seen in IDLE at cycle 0 → ISSUE in cycle 1 → WAIT in cycle 2 → ack in cycle 3. The next arbitration happens in cycle 4, so there are 4 cycles per access.
- Timeout path: ack arrives in cycle 2+TIMEOUT.
- Requesters must drop or change `req` in the cycle after their ack. A request still high in IDLE is treated as a new one.
- Back-to-back: the ram's ready clears before the next ISSUE, so no stale-ready hazard exists.
- Reset in any state: return to IDLE next cycle and drop the in-flight access. No ack is issued and the `last` pointer resets.

## Structure
- Package `mem_arb_pkg`:
  - state encoding `IDLE`/`ISSUE`/`WAIT`/`RESP`;
  - port ids `PORT_I` = 0, `PORT_D` = 1.
- Sub-module `rr_arb2`: combinational two-request round-robin picker. Inputs: `req[1:0]`, `last`. Outputs: `grant_valid`, `grant_id`.

## Test plan
- Single fetch: `i_req` with `i_addr` = 5, ram word 5 = 32'hDEADBEEF → `m_read` high in cycle 1 only, `i_ack` in cycle 3, `i_rdata` = 32'hDEADBEEF, `i_err` = 0.
- Data write then read: write 32'h12345678 to addr 10, then read addr 10 → `m_write` pulses once, `d_ack`/`d_err` = 0, then `d_rdata` = 32'h12345678.
- Contention: `i_req` and `d_req` held continuously from reset → grants alternate D, I, D, I with acks every 4 cycles.
- Out of range: data read of addr 2000 (mem_size 1024) → `d_ack` with `d_err` = 1. A following valid fetch of addr 0 returns `i_err` = 0.
- Timeout: ram model never responds, TIMEOUT = 4 → `i_ack` with `i_err` = 1 in cycle 6.
- Reset mid-access: assert `rst` during WAIT → no ack, `m_read`/`m_write` = 0. A pending `d_req` is served first after reset.
